bcd_seg_scan: RTL and testbench
===============================

BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, giving the clock cycles per digit slot (legal range 4..65535).
REQ-002 SHALL have parameter GUARD, default 16, giving the anode-off cycles at the start of each slot (legal range 1..CLK_DIV-2).
REQ-003 SHALL have port i_clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_bcd_data, input, 16 bits: four packed BCD digits, [15:12] thousands down to [3:0] units.
REQ-006 SHALL have port i_bcd_valid, input, 1 bit: single-cycle strobe qualifying i_bcd_data.
REQ-007 SHALL have port i_blank_lz, input, 1 bit: leading-zero blanking enable, sampled continuously.
REQ-008 SHALL have port o_an, output, 4 bits: registered active-low digit enables, bit k = digit k.
REQ-009 SHALL have port o_seg, output, 7 bits: registered active-low segments in order {g,f,e,d,c,b,a}.
REQ-010 SHALL have port o_digit_tick, output, 1 bit: registered one-cycle pulse on the first cycle of every slot.

Function
REQ-011 SHALL load the capture register from i_bcd_data on every edge where i_bcd_valid=1, with no backpressure; the last strobe wins.
REQ-012 SHALL run a prescaler counting 0..CLK_DIV-1 that wraps to 0; each wrap ends one slot.
REQ-013 SHALL increment the 2-bit digit index modulo 4 (3 wraps to 0) on the edge where the prescaler wraps.
REQ-014 SHALL copy the capture register into the snapshot register on the edge where the index wraps 3->0; the displayed digits SHALL come only from the snapshot.
REQ-015 SHALL give the snapshot the pre-edge capture value when a strobe coincides with the snapshot edge; the new data appears one scan later.
REQ-016 SHALL, on the wrap edge, drive o_an=4'b1111, o_seg=7'h7F and o_digit_tick=1; o_digit_tick SHALL be 0 on all other cycles.
REQ-017 SHALL, on the edge where the prescaler goes from GUARD-1 to GUARD, drive o_an with only the bit for the current index at 0, and drive o_seg with the decoded digit.
REQ-018 SHALL hold both outputs for the rest of the slot.
REQ-019 SHALL decode the digit to o_seg as follows: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-020 SHALL decode any digit value 10..15 to a dash, 7'h3F.
REQ-021 SHALL, when i_blank_lz=1, blank digit k (k=3..1) if snapshot digits k..3 are all zero; a blanked slot keeps o_an=1111 and o_seg=7F throughout.
REQ-022 SHALL never blank digit 0, so 0000 displays a single "0".
REQ-023 SHALL apply a change on i_blank_lz from the next GUARD edge.

Reset
REQ-024 SHALL, while i_reset_n=0, asynchronously clear the prescaler to 0 and the capture and snapshot registers to 0.
REQ-025 SHALL, while i_reset_n=0, asynchronously set the digit index to 3.
REQ-026 SHALL, while i_reset_n=0, asynchronously drive o_an=1111, o_seg=7F and o_digit_tick=0.
REQ-027 SHALL make the first wrap after release select digit 0 and load the snapshot, CLK_DIV cycles after the first active edge.
REQ-028 SHALL abandon any slot in progress on reset assertion, with no partial-output retention.

Verification (CLK_DIV=8, GUARD=2)
REQ-029 SHALL cover: strobe 16'h1234, run two scans -> slots show an=1110/seg=19, 1101/30, 1011/24, 0111/79; an=1111 for 2 cycles per slot; tick period 8.
REQ-030 SHALL cover: data 16'h0007 with i_blank_lz=1 -> only digit 0 lit (seg=78); with i_blank_lz=0 -> digits 3..1 show seg=40.
REQ-031 SHALL cover: data 16'h0000 with i_blank_lz=1 -> digit 0 shows 40 and digits 1..3 stay dark.
REQ-032 SHALL cover: data 16'h0A05 -> digit 2 shows dash 3F; digit 3 is blanked only when blank_lz=1.
REQ-033 SHALL cover: strobe 16'h9999 on the snapshot edge while showing 1234 -> the following scan still shows 1234 and the next scan shows 9999.
REQ-034 SHALL cover: i_reset_n pulsed low mid-slot of digit 2 -> outputs go 1111/7F/0 immediately and the first tick occurs 8 cycles after release with digit 0.

Source files
------------

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: 4-digit multiplexed 7-segment driver for packed BCD.
// Ports: i_clk, i_reset_n (async, low), i_bcd_data/i_bcd_valid capture,
//   i_blank_lz leading-zero blanking, o_an/o_seg active-low drives,
//   o_digit_tick one-cycle pulse on the first cycle of each slot.
module bcd_seg_scan #(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_bcd_data,
  input  logic        i_bcd_valid,
  input  logic        i_blank_lz,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_digit_tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(GUARD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   cap;
  logic [15:0]   snap;

  logic          wrap;
  logic          show;

  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic [3:0]    an_dec;
  logic          blank;

  assign wrap = (cnt == CNT_LAST);
  assign show = (cnt == CNT_SHOW);

  // Capture: last strobe wins, no backpressure.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cap <= '0;
    end else if (i_bcd_valid) begin
      cap <= i_bcd_data;
    end
  end

  // Prescaler, digit index and snapshot.
  // Index resets to 3 so the first wrap lands on digit 0
  // and loads the snapshot at the same time.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt  <= '0;
      idx  <= 2'd3;
      snap <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= idx + 2'd1;
      if (idx == 2'd3) begin
        snap <= cap;
      end
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Digit select from snapshot.
  always_comb begin
    nib    = snap[3:0];
    an_dec = 4'b1110;
    unique case (idx)
      2'd0: begin
        nib    = snap[3:0];
        an_dec = 4'b1110;
      end
      2'd1: begin
        nib    = snap[7:4];
        an_dec = 4'b1101;
      end
      2'd2: begin
        nib    = snap[11:8];
        an_dec = 4'b1011;
      end
      2'd3: begin
        nib    = snap[15:12];
        an_dec = 4'b0111;
      end
      default: begin
        nib    = snap[3:0];
        an_dec = 4'b1110;
      end
    endcase
  end

  // Digit k is blanked when it and every digit above it are zero.
  // Digit 0 is never blanked.
  always_comb begin
    blank = 1'b0;
    if (i_blank_lz) begin
      unique case (idx)
        2'd1:    blank = (snap[15:4]  == 12'h000);
        2'd2:    blank = (snap[15:8]  == 8'h00);
        2'd3:    blank = (snap[15:12] == 4'h0);
        default: blank = 1'b0;
      endcase
    end
  end

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  always_comb begin
    seg_dec = 7'h3F;
    unique case (nib)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h3F;
    endcase
  end

  // Outputs: dark at each slot start, lit after the guard,
  // held for the rest of the slot.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_an         <= AN_OFF;
      o_seg        <= SEG_OFF;
      o_digit_tick <= 1'b0;
    end else begin
      o_digit_tick <= wrap;
      if (wrap) begin
        o_an  <= AN_OFF;
        o_seg <= SEG_OFF;
      end else if (show) begin
        if (blank) begin
          o_an  <= AN_OFF;
          o_seg <= SEG_OFF;
        end else begin
          o_an  <= an_dec;
          o_seg <= seg_dec;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: scoreboard bench for bcd_seg_scan.
// Expected slot outputs are queued per scan and compared per slot.
module tb_bcd_seg_scan;

  localparam int CLK_DIV = 8;
  localparam int GUARD   = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_data;
  logic        bcd_valid;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        tick;

  bcd_seg_scan #(
    .CLK_DIV(CLK_DIV),
    .GUARD  (GUARD)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_bcd_data  (bcd_data),
    .i_bcd_valid (bcd_valid),
    .i_blank_lz  (blank_lz),
    .o_an        (an),
    .o_seg       (seg),
    .o_digit_tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [10:0] v;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   cur_valid;
  int   pos;
  int   tick_cnt;
  bit   have_prev;
  int   digit;
  int   checks;
  int   errors;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] exp_slot(input logic [15:0] d,
                                           input logic lz,
                                           input int k);
    logic [3:0]  nib;
    logic [6:0]  s;
    logic [15:0] hi;
    logic [3:0]  a;
    nib = d[4*k +: 4];
    hi  = d >> (4 * k);
    if (lz && k != 0 && hi == 16'h0) return 11'h7FF;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    a = 4'b0001 << k;
    a = ~a;
    return {a, s};
  endfunction

  task automatic push_scan(input logic [15:0] d, input logic lz);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.idx = k;
      e.v   = exp_slot(d, lz, k);
      q.push_back(e);
    end
  endtask

  // Slot monitor: dark guard, held lit value, tick period.
  always @(negedge clk) begin
    if (!rst_n) begin
      pos       = 0;
      tick_cnt  = 0;
      have_prev = 0;
      cur_valid = 0;
    end else begin
      if (tick) begin
        if (have_prev) chk("tick_period", pos + 1, CLK_DIV);
        have_prev = 1;
        pos       = 0;
        tick_cnt++;
      end else begin
        pos++;
      end
      digit = (tick_cnt - 1) & 3;
      if (pos < GUARD) begin
        chk("guard_dark", {21'h0, an, seg}, 32'h7FF);
      end else begin
        if (pos == GUARD) begin
          cur_valid = 0;
          if (q.size() > 0 && q[0].idx == digit) begin
            cur       = q.pop_front();
            cur_valid = 1;
          end
        end
        if (cur_valid)
          chk($sformatf("slot_d%0d", digit),
              {21'h0, an, seg}, {21'h0, cur.v});
      end
    end
  end

  task automatic wait_digit_tick(input int d);
    bit hit;
    hit = 0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk);
      #1;
      if (tick && (tick_cnt & 3) == d) hit = 1;
    end
    if (!hit) chk("tick_timeout", 0, 1);
  endtask

  // Strobe data late in digit 3 so the next scan shows it.
  task automatic scan(input logic [15:0] d, input logic lz);
    wait_digit_tick(3);
    repeat (GUARD) @(posedge clk);
    #1;
    blank_lz  = lz;
    bcd_data  = d;
    bcd_valid = 1'b1;
    push_scan(d, lz);
    @(posedge clk);
    #1;
    bcd_valid = 1'b0;
  endtask

  // Strobe exactly on the snapshot edge.
  task automatic snap_edge(input logic [15:0] old_d,
                           input logic [15:0] new_d);
    wait_digit_tick(3);
    push_scan(old_d, blank_lz);
    repeat (CLK_DIV - 1) @(posedge clk);
    #1;
    bcd_data  = new_d;
    bcd_valid = 1'b1;
    @(posedge clk);
    #1;
    bcd_valid = 1'b0;
    chk("snap_edge_tick", {31'h0, tick}, 1);
    push_scan(new_d, blank_lz);
  endtask

  task automatic reset_mid_slot();
    int n;
    wait_digit_tick(2);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_an",   {28'h0, an},   32'hF);
    chk("rst_seg",  {25'h0, seg},  32'h7F);
    chk("rst_tick", {31'h0, tick}, 0);
    push_scan(16'h0000, blank_lz);
    repeat (3) @(posedge clk);
    chk("rst_hold_an", {28'h0, an}, 32'hF);
    #2;
    rst_n = 1'b1;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (tick) break;
    end
    chk("first_tick_cycles", n, CLK_DIV);
    chk("first_tick_digit", tick_cnt & 3, 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    bcd_data  = 16'h0;
    bcd_valid = 1'b0;
    blank_lz  = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("init_an",   {28'h0, an},   32'hF);
    chk("init_seg",  {25'h0, seg},  32'h7F);
    chk("init_tick", {31'h0, tick}, 0);
    push_scan(16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    scan(16'h1234, 1'b0);
    scan(16'h1234, 1'b0);
    scan(16'h0007, 1'b1);
    scan(16'h0007, 1'b0);
    scan(16'h0000, 1'b1);
    scan(16'h0A05, 1'b0);
    scan(16'h0A05, 1'b1);
    scan(16'h1234, 1'b0);
    snap_edge(16'h1234, 16'h9999);
    wait_digit_tick(3);
    reset_mid_slot();

    wait_digit_tick(3);
    repeat (CLK_DIV) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
